// File: rtl/serializer_pkg.sv
// serializer_pkg: FSM state type and counter sizing shared by the MSB-first serializer.
package serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter must hold W itself, so it needs enough bits for W+1 values.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/leading_zero_counter.sv
// leading_zero_counter: combinational priority encoder returning the number of leading zeros (0..W).
// Present only when SERIALIZER_SKIP_LEADING_ZEROS_EN is defined.
`ifdef SERIALIZER_SKIP_LEADING_ZEROS_EN
module leading_zero_counter
    import serializer_pkg::*;
#(
    parameter int W = 8,
    localparam int CW = cnt_width(W)
) (
    input  logic [W-1:0]  data,
    output logic [CW-1:0] count
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++)
            if (data[i]) count = CW'(W - 1 - i);
    end

endmodule
`endif

// File: rtl/msb_first_word_serializer.sv
// msb_first_word_serializer: valid/ready word in, MSB-first bit stream out with first/last markers.
// Define SERIALIZER_SKIP_LEADING_ZEROS_EN to drop leading zeros (all-zero words emit a single 0).
module msb_first_word_serializer
    import serializer_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_bit,
    output logic         out_first,
    output logic         out_last
);

    localparam int CW = cnt_width(W);

    state_t        state, state_nxt;
    logic [W-1:0]  sreg, ld_data;
    logic [CW-1:0] cnt, ld_cnt;
    logic          first, accept, xfer;

`ifdef SERIALIZER_SKIP_LEADING_ZEROS_EN
    logic [CW-1:0] lz;

    leading_zero_counter #(.W(W)) u_lzc (
        .data  (in_data),
        .count (lz)
    );

    assign ld_data = in_data << lz;
    // An all-zero word still emits one bit so the downstream checker sees a complete number.
    assign ld_cnt  = (lz == CW'(W)) ? CW'(1) : CW'(W) - lz;
`else
    assign ld_data = in_data;
    assign ld_cnt  = CW'(W);
`endif

    assign accept = in_valid & in_ready;
    assign xfer   = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == IDLE) ? (accept ? SHIFT : IDLE)
                                    : ((xfer && out_last && !in_valid) ? IDLE : SHIFT);
    end

    always_comb begin
        out_valid = state == SHIFT;
        out_bit   = out_valid & sreg[W-1];
        out_first = out_valid & first;
        out_last  = out_valid & (cnt == CW'(1));
        in_ready  = !out_valid | (out_last & out_ready);
    end

    // A new word can only be accepted on the final transfer, so loading takes priority over shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg  <= '0;
            cnt   <= '0;
            first <= 1'b0;
        end else if (accept) begin
            sreg  <= ld_data;
            cnt   <= ld_cnt;
            first <= 1'b1;
        end else if (xfer) begin
            sreg  <= {sreg[W-2:0], 1'b0};
            cnt   <= cnt - CW'(1);
            first <= 1'b0;
        end
    end

endmodule

// File: tb/tb_msb_first_word_serializer.sv
// tb_msb_first_word_serializer: bit-queue model plus word scoreboard for the MSB-first serializer.
// Honours SERIALIZER_SKIP_LEADING_ZEROS_EN in both the model and the directed expectations.
module tb_msb_first_word_serializer;

    localparam int W = 8;

    typedef struct {
        logic b;
        logic f;
        logic l;
    } ebit_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_bit, out_first, out_last;

    msb_first_word_serializer #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_first (out_first),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int n_acc = 0, n_words = 0, valid_cycles = 0;
    int rdy_mode = 0, k = 0;
    logic chk_en = 1'b0;
    ebit_t q[$];
    logic [W-1:0] sb_q[$];
    logic [31:0] acc = 0, last_rx = 0;
    int len = 0, last_len = 0;

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endfunction

    function automatic void push_word(logic [W-1:0] w);
        int n = W;
`ifdef SERIALIZER_SKIP_LEADING_ZEROS_EN
        n = 1;
        for (int i = 0; i < W; i++) if (w[i]) n = i + 1;
`endif
        for (int i = n - 1; i >= 0; i--) q.push_back('{w[i], i == n - 1, i == 0});
    endfunction

    // Model: queue of the bits still owed for the current word.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            sb_q.delete();
        end else begin
            logic a;
            a = in_valid && (q.size() == 0 || (q.size() == 1 && out_ready));
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (a) begin
                push_word(in_data);
                sb_q.push_back(in_data);
                n_acc++;
            end
        end
    end

    // Per-cycle compare and word reassembly.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("in_ready", in_ready, q.size() == 0 || (q.size() == 1 && out_ready));
            chk("out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) begin
                chk("out_bit", out_bit, q[0].b);
                chk("out_first", out_first, q[0].f);
                chk("out_last", out_last, q[0].l);
            end else begin
                chk("out_bit_idle", out_bit, 0);
                chk("out_first_idle", out_first, 0);
                chk("out_last_idle", out_last, 0);
            end
            if (out_valid === 1'b1) valid_cycles++;
            if (out_valid === 1'b1 && out_ready) begin
                acc = out_first ? 32'(out_bit) : {acc[30:0], out_bit};
                len = out_first ? 1 : len + 1;
                if (out_last) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL word_unexpected: got %0h expected none", acc);
                    end else begin
                        logic [W-1:0] e;
                        e = sb_q.pop_front();
                        chk("word", acc, 32'(e));
                        chk("mod3", acc % 3, 32'(e) % 3);
                    end
                    last_rx = acc;
                    last_len = len;
                    n_words++;
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #2;
        out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (k % 3 == 0) : ($urandom_range(0, 3) != 0);
        k++;
    end

    task automatic send(input logic [W-1:0] w);
        int a0 = n_acc;
        in_valid = 1'b1;
        in_data = w;
        for (int i = 0; i < 500 && n_acc == a0; i++) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (n_acc == a0) begin
            n_bad++;
            $display("FAIL send_timeout: got no accept expected accept of %0h", w);
        end
        in_valid = 1'b0;
        in_data = W'($urandom);
    endtask

    task automatic wait_words(input int n);
        for (int i = 0; i < 20000 && n_words < n; i++) begin
            @(posedge clk);
            #1;
        end
        chk("words_done", n_words, n);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int nw;
        idle(2);
        rst = 1'b0;
        chk_en = 1'b1;

        // 10 unstalled
        send(8'd10);
        wait_words(1);
        chk("rx_10", last_rx, 10);
`ifdef SERIALIZER_SKIP_LEADING_ZEROS_EN
        chk("len_10", last_len, 4);
`else
        chk("len_10", last_len, 8);
`endif

        // back-to-back 255 then 3
        idle(2);
        valid_cycles = 0;
        send(8'd255);
        send(8'd3);
        wait_words(3);
        chk("rx_3", last_rx, 3);
`ifdef SERIALIZER_SKIP_LEADING_ZEROS_EN
        chk("b2b_cycles", valid_cycles, 10);
`else
        chk("b2b_cycles", valid_cycles, 16);
`endif

        // 6 with ready 1,0,0 repeating
        idle(2);
        rdy_mode = 1;
        send(8'd6);
        k = 0;
        valid_cycles = 0;
        wait_words(4);
        idle(1);
        rdy_mode = 0;
        chk("rx_6", last_rx, 6);
`ifdef SERIALIZER_SKIP_LEADING_ZEROS_EN
        chk("stall_cycles", valid_cycles, 7);
`else
        chk("stall_cycles", valid_cycles, 22);
`endif

        // reset on the 4th bit of 200
        idle(2);
        send(8'd200);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_no_word", n_words, 4);
        @(posedge clk);
        #1;
        send(8'd15);
        wait_words(5);
        chk("rx_15", last_rx, 15);

        // reset and in_valid together: reset wins
        idle(1);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'd77;
        idle(1);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_wins", out_valid, 0);
        @(posedge clk);
        #1;
        nw = 5;

`ifdef SERIALIZER_SKIP_LEADING_ZEROS_EN
        send(8'd5);
        wait_words(nw + 1);
        chk("skip_rx_5", last_rx, 5);
        chk("skip_len_5", last_len, 3);
        send(8'd0);
        wait_words(nw + 2);
        chk("skip_rx_0", last_rx, 0);
        chk("skip_len_0", last_len, 1);
        send(8'd128);
        wait_words(nw + 3);
        chk("skip_rx_128", last_rx, 128);
        chk("skip_len_128", last_len, 8);
        nw = nw + 3;
`endif

        // random sweep
        rdy_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            idle($urandom_range(0, 2));
            send(($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 7)) : W'($urandom_range(0, 255)));
        end
        wait_words(nw + 1000);
        rdy_mode = 0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/msb_first_word_serializer.md
# msb_first_word_serializer

- Upstream feeder for the serial divisibility checkers (`serial_divisibility_by_3/5_using_fsm`).
- Accepts a W-bit unsigned number through a valid/ready handshake and emits it one bit per transfer, MSB first.
- Each bit carries first/last markers. The downstream checker resets its remainder state on `out_first`, so its divisibility output for the complete number is valid on the cycle after the `out_last` transfer.

## Interface
- `W`, default 8: width of the input number in bits; legal range 2..32.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `in_valid` input, 1 bit: `in_data` holds a number to serialize.
- `in_ready` output, 1 bit: block can accept a word this cycle.
- `in_data` input, W bits: unsigned number, bit W-1 is the MSB.
- `out_valid` output, 1 bit: `out_bit`, `out_first` and `out_last` are meaningful.
- `out_ready` input, 1 bit: downstream consumes the current bit.
- `out_bit` output, 1 bit: current serial bit.
- `out_first` output, 1 bit: current bit is the first bit of a number.
- `out_last` output, 1 bit: current bit is the last bit (the LSB) of a number.

## Operation
- FSM states: IDLE and SHIFT.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid && in_ready`: load the shift register and the bit counter, set the first flag, go to SHIFT.
- SHIFT:
  - `out_valid`=1; `out_bit` = shift register MSB.
  - `out_first` = first flag; `out_last` = (counter == 1).
  - A transfer is `out_valid && out_ready`. On a transfer: shift left by 1, decrement the counter, clear the first flag.
  - No transfer: all outputs hold, so the output is stable under backpressure.
- Last-bit transfer:
  - `in_ready`=1 combinationally when in SHIFT with `out_last && out_ready`.
  - If `in_valid` is also high: load the new word, stay in SHIFT, set the first flag.
  - Otherwise: go to IDLE.
- `in_ready`=0 in SHIFT on all other cycles. Words are never dropped or overwritten.
- Counter width: $clog2(W+1). Counter values range 1..W.
- `in_data` is sampled only on the accept cycle; later changes have no effect.

## Timing
- Reset values: state=IDLE, `out_valid`=0, `out_first`=0, `out_last`=0, `out_bit`=0, counter=0, `in_ready`=1 from the cycle after reset.
- Latency: word accepted at cycle T; its first bit is valid at T+1 (registered output).
- Throughput with `out_ready` held high: one bit per cycle, W cycles per word. Back-to-back words have zero bubble cycles.
- Backpressure: `out_ready`=0 for N cycles stretches the word by exactly N cycles.
- Reset mid-word: the word is discarded. Next cycle `out_valid`=0 and `in_ready`=1; no partial `out_last` is emitted.
- `rst` and `in_valid` high in the same cycle: reset wins and the word is not accepted.

## Configuration
- `SERIALIZER_SKIP_LEADING_ZEROS_EN` defined:
  - At accept, the leading zeros of `in_data` are counted (value 0..W).
  - The shift register is loaded pre-shifted left by that count, and the counter is loaded with W minus that count.
  - An all-zero word emits exactly one bit, 0, with `out_first`=`out_last`=1.
  - Word length therefore varies from 1 to W bits. The remainder computed downstream is unchanged, because leading zeros do not affect it.
- Not defined: every word emits exactly W bits, including leading zeros, and no leading-zero logic is synthesized.

## Structure
- Package `serializer_pkg` holds:
  - state enum typedef (IDLE, SHIFT), 1-bit encoding;
  - function returning the counter width for a given W.
- Sub-module `leading_zero_counter` (parameter W):
  - combinational priority encoder;
  - instantiated only when `SERIALIZER_SKIP_LEADING_ZEROS_EN` is defined.
- Top module holds the FSM, shift register, counter and first flag.

## Test plan
- W=8, macro off, `out_ready`=1, input 8'd10 → bits 0,0,0,0,1,0,1,0 on cycles T+1..T+8; `out_first` on the first bit only, `out_last` on the eighth; chained `..._by_5` outputs 1 after the last bit.
- Back-to-back words 8'd255 then 8'd3 with `in_valid` held → second accepted on the last-bit cycle of the first; 16 consecutive valid bits with no gap; `in_ready`=0 on the other 14 cycles.
- Input 8'd6, `out_ready` toggling 1,0,0,1,… → bit sequence identical to the unstalled case; outputs stable while stalled; `out_last` appears once.
- Reset asserted on the 4th bit of 8'd200 → next cycle `out_valid`=0 and `in_ready`=1; next word 8'd15 serializes cleanly with `out_first` set.
- Macro on, inputs 8'd5 / 8'd0 / 8'd128 → emits 1,0,1 (3 bits) / 0 (1 bit, first=last=1) / 1,0,0,0,0,0,0,0 (8 bits).
- Random sweep of 1000 words, macro on and off → a scoreboard reassembles each word from `out_first`..`out_last`; reassembled value equals the input and the `..._by_3` result matches the input mod 3.
